multiply_tap: RTL and testbench
===============================

// Module: multiply_tap
// PURPOSE
//  One signed multiply tap for the FIR filter datapath: delayed sample x coefficient.
//  - Produces a full-precision 32-bit product for the filter's adder tree.
//  - One instance per tap; 63 instances in the 63-tap filter block.
//  - Registered, clock-enabled pipeline, so the filter can stall all taps together.
// PARAMETERS
//  LATENCY   1   Pipeline depth in enabled clock cycles, legal range 1..3.
//                 Values outside 1..3 are a compile-time error.
// PORTS
//  clk        in   1    Clock; all state updates on the rising edge.
//  rst_n      in   1    Reset, synchronous, active-low.
//  ena        in   1    Clock enable; when low, all pipeline state holds.
//  delay_x    in   16   Signed two's-complement sample from the tap delay line.
//  coef       in   16   Signed two's-complement filter coefficient.
//  acc        out  32   Signed product delay_x*coef, registered.
//  acc_valid  out  1    High when acc holds the product of an accepted operand pair.
//  Vector ordering for all vectors is [0:N-1], with bit 0 the MSB (sign bit).
//  Clock and reset: one clock; reset is synchronous and active-low (clk, rst_n).
// BEHAVIOUR
//  Arithmetic
//   - acc is the exact signed 16x16 product, sign-extended to 32 bits; no rounding, no saturation.
//   - The full range fits: -32768*-32768 = +2^30, and -32768*32767 = -1073709056.
//   - The internal structure (Booth, array, or inferred operator) is free, provided
//     the result is bit-exact for all 2^32 operand pairs.
//  Reset
//   - Sampled on the clk edge with rst_n low.
//   - Every pipeline stage, acc and acc_valid are cleared to 0.
//   - Reset has priority over ena.
//   - A reset in the middle of operation discards all in-flight products.
//  Pipeline
//   - Operands are captured on a rising edge with ena=1 and rst_n=1.
//   - The product appears on acc after exactly LATENCY such enabled edges.
//   - For LATENCY=1, acc on cycle k+1 equals delay_x*coef from edge k.
//   - ena=0: no stage advances; acc and acc_valid hold their values indefinitely.
//   - There is no operand capture while ena=0.
//   - acc_valid is a shift of '1' through LATENCY enabled stages after reset.
//     It stays high from then on, until the next reset.
//   - Back-to-back operands each enabled cycle give one product per cycle (throughput 1).
//  Boundary conditions
//   - A zero operand gives acc=0.
//   - Operands changing while ena=0 have no effect.
//   - Deasserting rst_n with ena=1 on the same edge: that edge is reset only, with no capture.
// TESTING
//  1 Reset: rst_n=0 for 2 edges with ena=1 and operands nonzero
//     -> acc=0x00000000 and acc_valid=0 after the first edge.
//  2 Basic (LATENCY=1): x=100, coef=0x007D (125), ena=1
//     -> next cycle acc=12500 (0x000030D4), acc_valid=1.
//  3 Corners:
//     x=32767, coef=0xFFFF -> acc=0xFFFF8001.
//     x=-32768, coef=-32768 -> acc=0x40000000.
//     x=-32768, coef=32767 -> acc=0xC0008000.
//  4 Stall: stream 1,2,3 with coef=5, then drop ena for 4 cycles while changing x
//     -> acc holds 15 throughout; resuming yields the next captured product.
//  5 Mid-stream reset (LATENCY=3): issue 3 operands, then pulse rst_n low 1 edge
//     -> acc=0 and acc_valid=0; no stale product emerges afterwards.
//  6 Random: 10k random pairs with random ena, compared against a reference model
//     -> bit-exact match at each LATENCY setting 1, 2 and 3.

Source files
------------

// File: rtl/multiply_tap.sv
// multiply_tap: one signed 16x16 -> 32 multiply tap of the FIR datapath (radix-4 Booth).
// Latency: LATENCY (1..3) enabled clock cycles from operand capture to acc; throughput one per enabled cycle.
// Backpressure: ena=0 freezes every stage, including acc and acc_valid; reset (sync, active-low) wins over ena.
module multiply_tap #(
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic [0:15] delay_x,
  input  logic [0:15] coef,
  output logic [0:31] acc,
  output logic        acc_valid
);

  // Reject unsupported pipeline depths at elaboration time.
  if (LATENCY < 1 || LATENCY > 3) begin : g_bad_latency
    $error("multiply_tap: LATENCY must be in 1..3");
  end

  // Port vectors are MSB-first; re-home them onto descending signed vectors.
  logic signed [15:0] x_s;
  logic signed [15:0] c_s;
  assign x_s = delay_x;
  assign c_s = coef;

  // One radix-4 Booth partial product: digit from bits {b[2i+1], b[2i], b[2i-1]}.
  function automatic logic signed [31:0] booth_pp(input logic signed [15:0] a,
                                                  input logic [2:0] trip,
                                                  input int idx);
    logic signed [31:0] ea;
    logic signed [31:0] pp;
    ea = 32'(a);
    case (trip)
      3'b001, 3'b010: pp = ea;
      3'b011:         pp = ea <<< 1;
      3'b100:         pp = -(ea <<< 1);
      3'b101, 3'b110: pp = -ea;
      default:        pp = 32'sd0;
    endcase
    return pp <<< (2 * idx);
  endfunction

  // Sum of Booth partial products first..last-1; the full product is booth_sum(a, b, 0, 8).
  function automatic logic signed [31:0] booth_sum(input logic signed [15:0] a,
                                                   input logic signed [15:0] b,
                                                   input int first,
                                                   input int last);
    logic [16:0]        b_ext;
    logic signed [31:0] sum;
    b_ext = {b, 1'b0};
    sum   = 32'sd0;
    for (int i = 0; i < 8; i++) begin
      if (i >= first && i < last) begin
        sum = sum + booth_pp(a, b_ext[2*i +: 3], i);
      end
    end
    return sum;
  endfunction

  logic signed [31:0] acc_q;
  assign acc = acc_q;

  if (LATENCY == 1) begin : g_lat1
    // Single stage: full Booth sum straight into the output register.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        acc_q <= 32'sd0;
      end else if (ena) begin
        acc_q <= booth_sum(x_s, c_s, 0, 8);
      end
    end
  end else if (LATENCY == 2) begin : g_lat2
    logic signed [15:0] x_r;
    logic signed [15:0] c_r;
    // Stage 1 registers the operands; stage 2 multiplies into acc.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        x_r   <= 16'sd0;
        c_r   <= 16'sd0;
        acc_q <= 32'sd0;
      end else if (ena) begin
        x_r   <= x_s;
        c_r   <= c_s;
        acc_q <= booth_sum(x_r, c_r, 0, 8);
      end
    end
  end else begin : g_lat3
    logic signed [15:0] x_r;
    logic signed [15:0] c_r;
    logic signed [31:0] sum_lo;
    logic signed [31:0] sum_hi;
    // Operands, then two half-sums of the partial products, then the final add.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        x_r    <= 16'sd0;
        c_r    <= 16'sd0;
        sum_lo <= 32'sd0;
        sum_hi <= 32'sd0;
        acc_q  <= 32'sd0;
      end else if (ena) begin
        x_r    <= x_s;
        c_r    <= c_s;
        sum_lo <= booth_sum(x_r, c_r, 0, 4);
        sum_hi <= booth_sum(x_r, c_r, 4, 8);
        acc_q  <= sum_lo + sum_hi;
      end
    end
  end

  logic [LATENCY-1:0] vld_sr;
  assign acc_valid = vld_sr[LATENCY-1];

  // A '1' walks through LATENCY enabled stages after reset and then sticks.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_sr <= '0;
    end else if (ena) begin
      vld_sr <= (vld_sr << 1) | LATENCY'(1);
    end
  end

endmodule

// File: tb/tb_multiply_tap.sv
// Bench for multiply_tap: LATENCY 1, 2 and 3 instances share one stimulus stream.
// Driver pushes hand-computed (or bench-computed) products; per-instance monitors pop and compare.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_multiply_tap;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b0;
  logic [0:15] x = '0;
  logic [0:15] coef = '0;
  logic [31:0] exp_p = '0;
  logic        tb_on = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  logic [0:31] acc_o [3];
  logic        vld_o [3];

  task automatic chk(input string name, input int lat, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s L%0d: got %h, want %h", name, lat, act, want);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    multiply_tap #(.LATENCY(g + 1)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ena      (ena),
      .delay_x  (x),
      .coef     (coef),
      .acc      (acc_o[g]),
      .acc_valid(vld_o[g])
    );

    logic [31:0] q[$];
    int          cnt = 0;
    logic [31:0] hold_acc = '0;
    logic        hold_vld = 1'b0;

    // Scoreboard monitor for this instance.
    always begin
      logic        s_r, s_e, s_on;
      logic [31:0] s_exp, got;
      @(posedge clk);
      s_r = rst_n; s_e = ena; s_on = tb_on; s_exp = exp_p;
      #1;
      if (s_on) begin
        if (!s_r) begin
          q.delete();
          cnt = 0;
          chk("reset_acc", g + 1, acc_o[g], 32'h0);
          chk("reset_vld", g + 1, {31'b0, vld_o[g]}, 32'h0);
        end else if (s_e) begin
          q.push_back(s_exp);
          if (cnt < g + 1) cnt++;
          chk("valid", g + 1, {31'b0, vld_o[g]}, {31'b0, (cnt >= g + 1)});
          if (vld_o[g]) begin
            if (q.size() == 0) begin
              chk("queue_empty", g + 1, 32'd0, 32'd1);
            end else begin
              got = acc_o[g];
              chk("product", g + 1, got, q.pop_front());
            end
          end
        end else begin
          chk("hold_acc", g + 1, acc_o[g], hold_acc);
          chk("hold_vld", g + 1, {31'b0, vld_o[g]}, {31'b0, hold_vld});
        end
        hold_acc = acc_o[g];
        hold_vld = vld_o[g];
      end
    end
  end

  task automatic drv(input logic r, input logic e, input logic signed [15:0] xv,
                     input logic signed [15:0] cv, input logic [31:0] ev);
    @(negedge clk);
    rst_n = r; ena = e; x = xv; coef = cv; exp_p = ev; tb_on = 1'b1;
  endtask

  initial begin
    // Reset for two edges with ena=1 and nonzero operands.
    drv(1'b0, 1'b1, 16'sd1234, 16'sd77, 32'h0);
    drv(1'b0, 1'b1, 16'sd1234, 16'sd77, 32'h0);
    // Basic product and corners.
    drv(1'b1, 1'b1, 16'sd100, 16'sd125, 32'h000030D4);
    drv(1'b1, 1'b1, 16'sd32767, -16'sd1, 32'hFFFF8001);
    drv(1'b1, 1'b1, -16'sd32768, -16'sd32768, 32'h40000000);
    drv(1'b1, 1'b1, -16'sd32768, 16'sd32767, 32'hC0008000);
    drv(1'b1, 1'b1, 16'sd0, 16'sd12345, 32'h0);
    drv(1'b1, 1'b1, -16'sd7, 16'sd0, 32'h0);
    drv(1'b1, 1'b1, -16'sd3, 16'sd7, 32'hFFFFFFEB);
    // Stream then stall while operands wiggle.
    drv(1'b1, 1'b1, 16'sd1, 16'sd5, 32'd5);
    drv(1'b1, 1'b1, 16'sd2, 16'sd5, 32'd10);
    drv(1'b1, 1'b1, 16'sd3, 16'sd5, 32'd15);
    drv(1'b1, 1'b0, 16'sd9, 16'sd5, 32'hDEAD0000);
    drv(1'b1, 1'b0, 16'sd11, 16'sd6, 32'hDEAD0001);
    drv(1'b1, 1'b0, -16'sd13, 16'sd7, 32'hDEAD0002);
    drv(1'b1, 1'b0, 16'sd17, 16'sd8, 32'hDEAD0003);
    drv(1'b1, 1'b1, 16'sd4, 16'sd5, 32'd20);
    drv(1'b1, 1'b1, 16'sd6, 16'sd5, 32'd30);
    drv(1'b1, 1'b1, 16'sd7, -16'sd3, 32'hFFFFFFEB);
    // Mid-stream reset: in-flight products must vanish.
    drv(1'b1, 1'b1, 16'sd1000, 16'sd1000, 32'd1000000);
    drv(1'b1, 1'b1, 16'sd2000, 16'sd3, 32'd6000);
    drv(1'b1, 1'b1, -16'sd50, 16'sd40, 32'hFFFFF830);
    drv(1'b0, 1'b1, 16'sd99, 16'sd99, 32'h0);
    drv(1'b1, 1'b1, 16'sd8, 16'sd8, 32'd64);
    drv(1'b1, 1'b0, 16'sd5, 16'sd5, 32'h0);
    drv(1'b1, 1'b1, 16'sd9, -16'sd9, 32'hFFFFFFAF);
    drv(1'b1, 1'b1, 16'sd256, 16'sd256, 32'h00010000);
    drv(1'b1, 1'b1, -16'sd1, -16'sd1, 32'd1);
    // Random pairs with random enable.
    for (int i = 0; i < 10000; i++) begin
      logic signed [15:0] xv, cv;
      int px, pc;
      xv = 16'($urandom);
      cv = 16'($urandom);
      px = xv;
      pc = cv;
      drv(1'b1, ($urandom_range(3, 0) != 0), xv, cv, 32'(px * pc));
    end
    // Flush the pipelines.
    for (int i = 0; i < 4; i++) drv(1'b1, 1'b1, 16'sd0, 16'sd0, 32'h0);
    @(negedge clk);
    tb_on = 1'b0;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
